// File: rtl/ring_router_demux_reg.sv
// Registered two-way demultiplexer for the debug ring: steers whole DII worms to
// the local port or back onto the ring, decided by the destination in the header flit.
module ring_router_demux_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] id_i,
  input  logic [15:0] in_data_i,
  input  logic        in_last_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [15:0] out_local_data_o,
  output logic        out_local_last_o,
  output logic        out_local_valid_o,
  input  logic        out_local_ready_i,
  output logic [15:0] out_ring_data_o,
  output logic        out_ring_last_o,
  output logic        out_ring_valid_o,
  input  logic        out_ring_ready_i
);

  typedef enum logic [1:0] {
    HDR    = 2'd0,
    WLOCAL = 2'd1,
    WRING  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        buf_valid_q, buf_valid_d;
  logic [15:0] buf_data_q, buf_data_d;
  logic        buf_last_q, buf_last_d;
  logic        buf_sel_q, buf_sel_d;   // 1 = LOCAL, 0 = RING
  logic        sel_in;
  logic        sel_ready;
  logic        accept;

  // Only the header is decoded; body flits inherit the selection held in the state.
  always_comb begin
    sel_in = 1'b0;
    unique case (state_q)
      HDR:     sel_in = (in_data_i == id_i);
      WLOCAL:  sel_in = 1'b1;
      WRING:   sel_in = 1'b0;
      default: sel_in = 1'b0;
    endcase
  end

  assign sel_ready  = buf_sel_q ? out_local_ready_i : out_ring_ready_i;
  assign in_ready_o = !buf_valid_q | sel_ready;
  assign accept     = in_valid_i & in_ready_o;

  // State register and output-buffer control (reset only touches control state).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HDR;
      buf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_data_q <= buf_data_d;
    buf_last_q <= buf_last_d;
    buf_sel_q  <= buf_sel_d;
  end

  // Next-state: transitions happen only on accepted flits.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        HDR:           if (!in_last_i) state_d = sel_in ? WLOCAL : WRING;
        WLOCAL, WRING: if (in_last_i) state_d = HDR;
        default:       state_d = HDR;
      endcase
    end
  end

  // Output register: load on accept (covers simultaneous drain+load), else drain.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_data_d  = buf_data_q;
    buf_last_d  = buf_last_q;
    buf_sel_d   = buf_sel_q;
    if (accept) begin
      buf_valid_d = 1'b1;
      buf_data_d  = in_data_i;
      buf_last_d  = in_last_i;
      buf_sel_d   = sel_in;
    end else if (buf_valid_q && sel_ready) begin
      buf_valid_d = 1'b0;
    end
  end

  assign out_local_valid_o = buf_valid_q &  buf_sel_q;
  assign out_ring_valid_o  = buf_valid_q & ~buf_sel_q;
  assign out_local_data_o  = buf_data_q;
  assign out_local_last_o  = buf_last_q;
  assign out_ring_data_o   = buf_data_q;
  assign out_ring_last_o   = buf_last_q;

endmodule

// File: tb/tb_ring_router_demux_reg.sv
// Directed bench for ring_router_demux_reg: header decode, worm steering,
// backpressure, head-of-line blocking and mid-worm reset.
module tb_ring_router_demux_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] id = 16'h0005;
  logic [15:0] in_data = 16'h0;
  logic        in_last = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] loc_data;
  logic        loc_last, loc_valid;
  logic        loc_ready = 1'b1;
  logic [15:0] ring_data;
  logic        ring_last, ring_valid;
  logic        ring_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ring_router_demux_reg dut (
    .clk               (clk),
    .rst               (rst),
    .id_i              (id),
    .in_data_i         (in_data),
    .in_last_i         (in_last),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .out_local_data_o  (loc_data),
    .out_local_last_o  (loc_last),
    .out_local_valid_o (loc_valid),
    .out_local_ready_i (loc_ready),
    .out_ring_data_o   (ring_data),
    .out_ring_last_o   (ring_last),
    .out_ring_valid_o  (ring_valid),
    .out_ring_ready_i  (ring_ready)
  );

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] d, input logic l, input logic v);
    in_data  = d;
    in_last  = l;
    in_valid = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(16'h0, 1'b0, 1'b0);
    cyc();
    cyc();
    checks++;
    if (loc_valid !== 1'b0) begin errors++; $display("FAIL reset_loc_valid got %b exp 0", loc_valid); end
    checks++;
    if (ring_valid !== 1'b0) begin errors++; $display("FAIL reset_ring_valid got %b exp 0", ring_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single_local();
    drive(16'h0005, 1'b1, 1'b1);
    cyc();
    drive(16'h0, 1'b0, 1'b0);
    checks++;
    if ({loc_valid, loc_data, loc_last} !== {1'b1, 16'h0005, 1'b1}) begin
      errors++; $display("FAIL single_local got v=%b d=%h l=%b exp v=1 d=0005 l=1", loc_valid, loc_data, loc_last);
    end
    checks++;
    if (ring_valid !== 1'b0) begin errors++; $display("FAIL single_local_ring got %b exp 0", ring_valid); end
    cyc();
    checks++;
    if (loc_valid !== 1'b0) begin errors++; $display("FAIL single_local_drain got %b exp 0", loc_valid); end
    // state must still be HDR: a ring header right after is decoded, not steered local
    drive(16'h0007, 1'b1, 1'b1);
    cyc();
    drive(16'h0, 1'b0, 1'b0);
    checks++;
    if ({ring_valid, loc_valid, ring_data} !== {1'b1, 1'b0, 16'h0007}) begin
      errors++; $display("FAIL single_state_hdr got rv=%b lv=%b d=%h exp rv=1 lv=0 d=0007", ring_valid, loc_valid, ring_data);
    end
    cyc();
  endtask

  task automatic test_ring_worm();
    logic [15:0] w [3];
    w[0] = 16'h0009; w[1] = 16'hAAAA; w[2] = 16'hBBBB;
    for (int i = 0; i < 3; i++) begin
      drive(w[i], (i == 2), 1'b1);
      cyc();
      checks++;
      if ({ring_valid, ring_data, ring_last, loc_valid} !== {1'b1, w[i], (i == 2), 1'b0}) begin
        errors++;
        $display("FAIL ring_worm[%0d] got rv=%b d=%h l=%b lv=%b exp rv=1 d=%h l=%b lv=0",
                 i, ring_valid, ring_data, ring_last, loc_valid, w[i], (i == 2));
      end
    end
    drive(16'h0, 1'b0, 1'b0);
    cyc();
    checks++;
    if ({ring_valid, loc_valid} !== 2'b00) begin errors++; $display("FAIL ring_worm_idle got %b exp 00", {ring_valid, loc_valid}); end
  endtask

  task automatic test_body_match_id();
    drive(16'h0009, 1'b0, 1'b1);
    cyc();
    checks++;
    if ({ring_valid, ring_data} !== {1'b1, 16'h0009}) begin
      errors++; $display("FAIL body_hdr got v=%b d=%h exp v=1 d=0009", ring_valid, ring_data);
    end
    drive(16'h0005, 1'b1, 1'b1);
    cyc();
    drive(16'h0, 1'b0, 1'b0);
    checks++;
    if ({ring_valid, ring_data, ring_last, loc_valid} !== {1'b1, 16'h0005, 1'b1, 1'b0}) begin
      errors++; $display("FAIL body_no_redecode got rv=%b d=%h l=%b lv=%b exp rv=1 d=0005 l=1 lv=0", ring_valid, ring_data, ring_last, loc_valid);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    drive(16'h0005, 1'b0, 1'b1);
    cyc();
    checks++;
    if ({loc_valid, loc_data, loc_last, ring_valid} !== {1'b1, 16'h0005, 1'b0, 1'b0}) begin
      errors++; $display("FAIL b2b_loc0 got lv=%b d=%h l=%b rv=%b exp lv=1 d=0005 l=0 rv=0", loc_valid, loc_data, loc_last, ring_valid);
    end
    drive(16'h1111, 1'b1, 1'b1);
    cyc();
    checks++;
    if ({loc_valid, loc_data, loc_last} !== {1'b1, 16'h1111, 1'b1}) begin
      errors++; $display("FAIL b2b_loc1 got lv=%b d=%h l=%b exp lv=1 d=1111 l=1", loc_valid, loc_data, loc_last);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", in_ready); end
    drive(16'h0007, 1'b1, 1'b1);
    cyc();
    drive(16'h0, 1'b0, 1'b0);
    checks++;
    if ({ring_valid, ring_data, ring_last, loc_valid} !== {1'b1, 16'h0007, 1'b1, 1'b0}) begin
      errors++; $display("FAIL b2b_ring got rv=%b d=%h l=%b lv=%b exp rv=1 d=0007 l=1 lv=0", ring_valid, ring_data, ring_last, loc_valid);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    ring_ready = 1'b0;
    drive(16'h0009, 1'b0, 1'b1);
    cyc();
    drive(16'hAAAA, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({ring_valid, ring_data, in_ready} !== {1'b1, 16'h0009, 1'b0}) begin
        errors++; $display("FAIL bp_hold[%0d] got rv=%b d=%h rdy=%b exp rv=1 d=0009 rdy=0", i, ring_valid, ring_data, in_ready);
      end
      cyc();
    end
    ring_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got %b exp 1", in_ready); end
    cyc();
    checks++;
    if ({ring_valid, ring_data, ring_last} !== {1'b1, 16'hAAAA, 1'b0}) begin
      errors++; $display("FAIL bp_resume1 got rv=%b d=%h l=%b exp rv=1 d=aaaa l=0", ring_valid, ring_data, ring_last);
    end
    drive(16'hBBBB, 1'b1, 1'b1);
    cyc();
    drive(16'h0, 1'b0, 1'b0);
    checks++;
    if ({ring_valid, ring_data, ring_last} !== {1'b1, 16'hBBBB, 1'b1}) begin
      errors++; $display("FAIL bp_resume2 got rv=%b d=%h l=%b exp rv=1 d=bbbb l=1", ring_valid, ring_data, ring_last);
    end
    cyc();
    checks++;
    if (ring_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got %b exp 0", ring_valid); end
  endtask

  task automatic test_hol_block();
    loc_ready = 1'b0;
    drive(16'h0005, 1'b1, 1'b1);
    cyc();
    drive(16'h0007, 1'b1, 1'b1);
    cyc();
    checks++;
    if ({loc_valid, ring_valid, in_ready} !== 3'b100) begin
      errors++; $display("FAIL hol_block got lv=%b rv=%b rdy=%b exp lv=1 rv=0 rdy=0", loc_valid, ring_valid, in_ready);
    end
    loc_ready = 1'b1;
    cyc();
    drive(16'h0, 1'b0, 1'b0);
    checks++;
    if ({ring_valid, ring_data, loc_valid} !== {1'b1, 16'h0007, 1'b0}) begin
      errors++; $display("FAIL hol_release got rv=%b d=%h lv=%b exp rv=1 d=0007 lv=0", ring_valid, ring_data, loc_valid);
    end
    cyc();
  endtask

  task automatic test_reset_mid_worm();
    drive(16'h0009, 1'b0, 1'b1);
    cyc();
    drive(16'hAAAA, 1'b0, 1'b1);
    cyc();
    rst = 1'b1;
    drive(16'h0, 1'b0, 1'b0);
    cyc();
    rst = 1'b0;
    checks++;
    if ({loc_valid, ring_valid, in_ready} !== 3'b001) begin
      errors++; $display("FAIL midrst_clear got lv=%b rv=%b rdy=%b exp lv=0 rv=0 rdy=1", loc_valid, ring_valid, in_ready);
    end
    drive(16'h0005, 1'b1, 1'b1);
    cyc();
    drive(16'h0, 1'b0, 1'b0);
    checks++;
    if ({loc_valid, loc_data, loc_last, ring_valid} !== {1'b1, 16'h0005, 1'b1, 1'b0}) begin
      errors++; $display("FAIL midrst_header got lv=%b d=%h l=%b rv=%b exp lv=1 d=0005 l=1 rv=0", loc_valid, loc_data, loc_last, ring_valid);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_local();
    test_ring_worm();
    test_body_match_id();
    test_back_to_back();
    test_backpressure();
    test_hol_block();
    test_reset_mid_worm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ring_router_demux_reg.md
# ring_router_demux_reg

Registered two-way demultiplexer for the debug ring. It accepts DII worms from the incoming ring link and steers each whole packet to the local port or back onto the ring, based on the destination word in the packet's first flit. It sits directly upstream of the ring mux: its `out_ring` feeds the mux's forwarding input. A one-entry output register breaks the combinational valid/ready path between the link and the downstream mux and local endpoint.

## Interface
- No parameters. The flit width is fixed by `dii_channel`: 16-bit `data`, plus `last`, `valid` and `ready`.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `id`  input  16  this router's DII address. It must be stable while `rst` is low; changes take effect at the next header flit.
- `in`  dii_channel (slave)  16+1+1+1  incoming ring flits.
- `out_local`  dii_channel (master)  16+1+1+1  packets addressed to `id`.
- `out_ring`  dii_channel (master)  16+1+1+1  all other packets, forwarded on the ring.

## Operation
- **Header flit.** The flit accepted while `state==HDR` is a header. Its destination is `in.data[15:0]`.
  - If the destination equals `id`, select LOCAL; otherwise select RING.
  - If the header has `last=1`, the packet is one flit long and `state` stays HDR.
  - If `last=0`, `state` goes to WLOCAL or WRING to match the selection.
- **Body flits.** In WLOCAL or WRING, every accepted flit takes the held selection. The header is not re-decoded.
  - The accepted flit with `last=1` returns `state` to HDR.
- **Output register.** The register holds `buf_valid`, `buf_data[15:0]`, `buf_last` and `buf_sel` (LOCAL/RING).
  - `out_local.valid = buf_valid & (buf_sel==LOCAL)`.
  - `out_ring.valid = buf_valid & (buf_sel==RING)`.
  - Both outputs always drive `data=buf_data` and `last=buf_last`. Their values are meaningless while the matching `valid` is 0.
  - `sel_ready` is the `ready` of the output chosen by `buf_sel`.
  - `in.ready = !buf_valid | sel_ready`. This is combinational: the register can drain and refill in the same cycle.
  - `in.ready` never depends on `in.valid`. It may depend on the selected `out.ready`.
- **Register update, per cycle:**
  - Input accepted (`in.valid & in.ready`): load the flit and its computed selection, and set `buf_valid=1`.
  - Otherwise, output drained (`buf_valid & sel_ready`): set `buf_valid=0`.
  - Otherwise: hold all register contents.
- **Per-output ordering.** Flits leave each output in the order they were accepted.
  - A packet is never split across outputs.
  - Flits of different packets never interleave on one output.
- **Head-of-line blocking.** A stalled output blocks all input traffic. No bypass to the other output.
- **States:** HDR, WLOCAL, WRING. Transitions happen only on accepted input flits.

## Timing
- **Reset.** On `rst` at a clock edge:
  - `state` goes to HDR.
  - `buf_valid` goes to 0, so both `out_*.valid` are 0 in the cycle after the reset edge.
  - `in.ready` is 1 in the cycle after the reset edge.
  - `buf_data`, `buf_last` and `buf_sel` are not reset.
- **Reset mid-operation.** A reset mid-worm discards the buffered flit and any partial packet. The next accepted flit is treated as a header.
- **Latency.** A flit accepted at edge N is visible on its output during cycle N+1, i.e. exactly one cycle of latency.
- **Throughput.** One flit per cycle when the selected output holds `ready=1`.
- **Valid stability.** Once `out_*.valid` is asserted it stays asserted, with stable data and last, until that output's ready is seen. No retraction.
- **Packet switch.** When a packet switches outputs (last flit to LOCAL, then a header to RING), there is no bubble if the LOCAL output is ready while the last flit is in the register.
- **Simultaneous drain and load.** Legal: the register ends valid with the new flit.
- **Input protocol.** The block relies on the upstream holding valid and data stable until ready is seen. It does not check this.

## Test plan
- **Single-flit local packet.** `id=0x0005`; present `in={data=0x0005,last=1}` with both readies high.
  - Expect `out_local.valid` 1 cycle later with data `0x0005`, `last=1`.
  - `out_ring.valid` stays 0, and `state` remains HDR.
- **Three-flit forward worm.** Present `0x0009,0xAAAA,0xBBBB(last)` back-to-back.
  - Expect `out_ring` to carry exactly those 3 flits on 3 consecutive cycles, starting 1 cycle after the first is accepted.
  - `out_local.valid` stays 0 throughout.
- **Body flit matching `id`.** Send a worm with header `0x0009` whose body word is `0x0005` (equal to `id`).
  - Expect the body to go to `out_ring`, with no re-decode.
- **Back-to-back packets to different outputs.** Send local 2-flit `0x0005,0x1111(last)`, then immediately ring 1-flit `0x0007(last)`.
  - Expect `out_local` to get 2 flits, then `out_ring` to get `0x0007` on the next cycle, with no idle cycle.
- **Backpressure.** `out_ring.ready=0` for 4 cycles while a ring worm is streaming.
  - Expect `in.ready=0` after one flit is buffered.
  - `out_ring.valid` held with constant data.
  - No flit lost or duplicated after ready rises.
- **Reset mid-worm.** Assert `rst` after flit 2 of a 4-flit ring worm; release it, then send `0x0005(last)`.
  - Expect both valids 0 in the cycle after reset.
  - Expect the new flit to be decoded as a header and delivered on `out_local`.
